// File: rtl/memif_wide_pkg.sv
`default_nettype none
//============================================================================
// Module      : memif_wide_pkg
// Description : Shared constants for the memif_wide register-to-memory
//               bridge: FSM state encoding, slave register indices and
//               CTRL/STAT bit positions.
// Revision    : 1.0 - initial release
//============================================================================
package memif_wide_pkg;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MWR  = 2'd1;
    localparam logic [1:0] ST_MRD  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Slave register word indices
    localparam int REG_ADDR  = 0;
    localparam int REG_CTRL  = 1;
    localparam int REG_LANE0 = 2;

    // CTRL/STAT bit positions
    localparam int CTRL_AUTOINC = 0;
    localparam int CTRL_BUSY    = 1;
    localparam int CTRL_ERR     = 2;

endpackage
`default_nettype wire

// File: rtl/memif_wide_lanes.sv
`default_nettype none
//============================================================================
// Module      : memif_wide_lanes
// Description : DW-bit data word held as DW/32 slave-visible 32-bit lanes.
//               Lane k lives at slave address REG_LANE0+k.
// Ports       : clk, reset      - clock, synchronous active-high reset
//               wr_en, addr,    - slave lane write (decoded from addr)
//               wdata
//               load_en,        - whole-word load from the master side
//               load_data
//               word            - full data word (master write data)
//               rdata           - lane read mux, 0 for non-lane addresses
// Revision    : 1.0 - initial release
//============================================================================
module memif_wide_lanes
    import memif_wide_pkg::*;
#(
    parameter int DW  = 64,
    parameter int SAW = 2
)(
    input  logic           clk,
    input  logic           reset,
    input  logic           wr_en,
    input  logic [SAW-1:0] addr,
    input  logic [31:0]    wdata,
    input  logic           load_en,
    input  logic [DW-1:0]  load_data,
    output logic [DW-1:0]  word,
    output logic [31:0]    rdata
);

    localparam int LANES = DW / 32;

    logic [31:0] r_lane [LANES];

    // Slave writes and master loads are never simultaneous (IDLE vs MRD),
    // the load still takes priority for safety.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (reset) begin
                r_lane[i] <= '0;
            end else if (load_en) begin
                r_lane[i] <= load_data[32*i +: 32];
            end else if (wr_en && (addr == SAW'(REG_LANE0 + i))) begin
                r_lane[i] <= wdata;
            end
        end
    end

    always_comb begin
        rdata = '0;
        for (int i = 0; i < LANES; i++) begin
            if (addr == SAW'(REG_LANE0 + i)) begin
                rdata = r_lane[i];
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < LANES; g++) begin : g_pack
            assign word[32*g +: 32] = r_lane[g];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/memif_wide.sv
`default_nettype none
//============================================================================
// Module      : memif_wide
// Description : 32-bit Avalon-MM slave register window driving one DW-bit
//               Avalon-MM master transfer per top-lane access.
//               Map: 0=ADDR, 1=CTRL/STAT (AUTOINC, BUSY, ERR), 2..LANES+1
//               = data lanes. Top lane access starts the master transfer.
// Ports       : clk, reset                 - clock, sync active-high reset
//               s_address/s_write/s_read/  - 32-bit slave side
//               s_writedata/s_readdata/s_waitrequest
//               m_address/m_write/m_read/  - DW-bit master side
//               m_writedata/m_readdata/m_waitrequest
// Options     : MEMIF_WIDE_TIMEOUT_EN - master watchdog; after TIMEOUT
//               stalled cycles the transfer is abandoned and ERR is set.
// Revision    : 1.0 - initial release
//============================================================================
module memif_wide
    import memif_wide_pkg::*;
#(
    parameter int DW      = 64,
    parameter int AW      = 32,
    parameter int SAW     = 2,
    parameter int TIMEOUT = 1024
)(
    input  logic           clk,
    input  logic           reset,
    input  logic [SAW-1:0] s_address,
    input  logic           s_write,
    input  logic           s_read,
    input  logic [31:0]    s_writedata,
    output logic [31:0]    s_readdata,
    output logic           s_waitrequest,
    output logic [AW-1:0]  m_address,
    output logic           m_write,
    output logic           m_read,
    output logic [DW-1:0]  m_writedata,
    input  logic [DW-1:0]  m_readdata,
    input  logic           m_waitrequest
);

    localparam int             LANES  = DW / 32;
    localparam logic [SAW-1:0] TOP    = SAW'(LANES + 1);
    localparam logic [SAW-1:0] A_ADDR = SAW'(REG_ADDR);
    localparam logic [SAW-1:0] A_CTRL = SAW'(REG_CTRL);

    logic [1:0]    r_state;
    logic [AW-1:0] r_addr;
    logic          r_autoinc;
    logic          r_mwr;
    logic          r_mrd;

    logic          w_access;
    logic          w_start;
    logic          w_xfer;
    logic          w_err;
    logic          w_inc_ok;
    logic          w_lane_wr;
    logic          w_lane_load;
    logic [31:0]   w_lane_rdata;
    logic [31:0]   w_ctrl;
    logic [DW-1:0] w_word;

    assign w_access = s_write | s_read;
    assign w_start  = (r_state == ST_IDLE) && w_access && (s_address == TOP);
    assign w_xfer   = (r_state == ST_MWR) || (r_state == ST_MRD);

`ifdef MEMIF_WIDE_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_cnt;
    logic          r_err;
    logic          r_timed_out;
    logic          w_expire;

    // Fires on the stalled cycle that brings the count up to TIMEOUT.
    assign w_expire = w_xfer && m_waitrequest && (r_cnt == CW'(TIMEOUT - 1));
    assign w_err    = r_err;
    // An abandoned transfer must not advance the address.
    assign w_inc_ok = r_autoinc && !r_timed_out;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= '0;
            r_err       <= 1'b0;
            r_timed_out <= 1'b0;
        end else begin
            if (w_start) begin
                r_cnt <= '0;
            end else if (w_xfer && m_waitrequest) begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_expire) begin
                r_err <= 1'b1;
            end else if ((r_state == ST_IDLE) && s_write && (s_address == A_CTRL)
                         && s_writedata[CTRL_ERR]) begin
                r_err <= 1'b0;
            end

            if (w_expire) begin
                r_timed_out <= 1'b1;
            end else if (r_state == ST_DONE) begin
                r_timed_out <= 1'b0;
            end
        end
    end
`else
    assign w_err    = 1'b0;
    assign w_inc_ok = r_autoinc;
`endif

    // Only a top-lane start or a slave access during the master transfer
    // stalls; DONE releases the pending access.
    assign s_waitrequest = w_start || (w_xfer && w_access);

    // Lane writes happen only in IDLE; the top-lane write of a start is
    // captured on the start edge so m_writedata is complete in MWR.
    assign w_lane_wr   = (r_state == ST_IDLE) && s_write;
    assign w_lane_load = (r_state == ST_MRD) && !m_waitrequest;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_addr    <= '0;
            r_autoinc <= 1'b0;
            r_mwr     <= 1'b0;
            r_mrd     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (s_write && (s_address == A_ADDR)) begin
                        r_addr <= AW'(s_writedata);
                    end
                    if (s_write && (s_address == A_CTRL)) begin
                        r_autoinc <= s_writedata[CTRL_AUTOINC];
                    end
                    if (w_start) begin
                        // Write wins when both strobes are high.
                        if (s_write) begin
                            r_mwr   <= 1'b1;
                            r_state <= ST_MWR;
                        end else begin
                            r_mrd   <= 1'b1;
                            r_state <= ST_MRD;
                        end
                    end
                end
                ST_MWR, ST_MRD: begin
                    if (!m_waitrequest) begin
                        r_mwr   <= 1'b0;
                        r_mrd   <= 1'b0;
                        r_state <= ST_DONE;
                    end
`ifdef MEMIF_WIDE_TIMEOUT_EN
                    else if (w_expire) begin
                        r_mwr   <= 1'b0;
                        r_mrd   <= 1'b0;
                        r_state <= ST_DONE;
                    end
`endif
                end
                default: begin
                    if (w_inc_ok) begin
                        r_addr <= r_addr + AW'(DW / 8);
                    end
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    memif_wide_lanes #(
        .DW  (DW),
        .SAW (SAW)
    ) u_lanes (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (w_lane_wr),
        .addr      (s_address),
        .wdata     (s_writedata),
        .load_en   (w_lane_load),
        .load_data (m_readdata),
        .word      (w_word),
        .rdata     (w_lane_rdata)
    );

    always_comb begin
        w_ctrl               = '0;
        w_ctrl[CTRL_AUTOINC] = r_autoinc;
        w_ctrl[CTRL_BUSY]    = (r_state != ST_IDLE);
        w_ctrl[CTRL_ERR]     = w_err;
    end

    always_comb begin
        s_readdata = w_lane_rdata;
        if (s_address == A_ADDR) begin
            s_readdata = 32'(r_addr);
        end else if (s_address == A_CTRL) begin
            s_readdata = w_ctrl;
        end
    end

    assign m_address   = r_addr;
    assign m_write     = r_mwr;
    assign m_read      = r_mrd;
    assign m_writedata = w_word;

endmodule
`default_nettype wire
